// File: rtl/wb_port_arbiter.sv
// wb_port_arbiter: round-robin share of the register-file write port among mem, pc and alu writeback sources
module wb_port_arbiter #(
    parameter int DATA_W        = 32,
    parameter int ADDR_W        = 5,
    parameter bit ZERO_REG_DROP = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mem_valid,
    input  logic [ADDR_W-1:0] mem_rd,
    input  logic [DATA_W-1:0] mem_data,
    output logic              mem_ready,
    input  logic              pc_valid,
    input  logic [ADDR_W-1:0] pc_rd,
    input  logic [DATA_W-1:0] pc_data,
    output logic              pc_ready,
    input  logic              alu_valid,
    input  logic [ADDR_W-1:0] alu_rd,
    input  logic [DATA_W-1:0] alu_data,
    output logic              alu_ready,
    input  logic              wb_hold,
    output logic              wb_en,
    output logic [ADDR_W-1:0] wb_rd,
    output logic [DATA_W-1:0] wb_data,
    output logic [1:0]        mem_reg_pc,
    output logic              stall
);
    logic [2:0]        req, gnt;
    logic [1:0]        ptr, i1, i2, gi;
    logic [ADDR_W-1:0] g_rd;
    logic [DATA_W-1:0] g_data;
    logic              wr;

    // search order starts after the last granted source (0 mem, 1 pc, 2 alu)
    always_comb begin
        req    = {alu_valid, pc_valid, mem_valid} & {3{~wb_hold & ~rst}};
        i1     = ptr == 2'd2 ? 2'd0 : ptr + 2'd1;
        i2     = i1 == 2'd2 ? 2'd0 : i1 + 2'd1;
        gnt    = req[i1] ? 3'b001 << i1 : req[i2] ? 3'b001 << i2 : req[ptr] ? 3'b001 << ptr : 3'b000;
        gi     = gnt[0] ? 2'd0 : gnt[1] ? 2'd1 : 2'd2;
        g_rd   = gnt[0] ? mem_rd : gnt[1] ? pc_rd : alu_rd;
        g_data = gnt[0] ? mem_data : gnt[1] ? pc_data : alu_data;
        wr     = |gnt && !(ZERO_REG_DROP && g_rd == '0);
    end

    assign {alu_ready, pc_ready, mem_ready} = gnt;
    assign stall = |({alu_valid, pc_valid, mem_valid} & ~gnt);

    // pointer follows completed grants; write stage registers the winner one cycle later
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr        <= 2'd2;
            wb_en      <= 1'b0;
            wb_rd      <= '0;
            wb_data    <= '0;
            mem_reg_pc <= 2'b00;
        end else begin
            if (|gnt) ptr <= gi;
            wb_en      <= wr;
            mem_reg_pc <= wr ? gi + 2'd1 : 2'b00;
            if (wr) begin
                wb_rd   <= g_rd;
                wb_data <= g_data;
            end
        end
    end
endmodule
